// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular-exponentiation unit: sequencer states,
// Montgomery-multiplier operand selects and MonPro cycle cost.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE, MBAR, XINIT, SQ, MUL, CONV, DONE, HOLD
    } state_e;

    typedef enum logic [2:0] {
        SEL_ONE, SEL_CONST, SEL_M, SEL_MB, SEL_X
    } opsel_e;

    // One dispatch cycle, one subtract cycle, one writeback cycle on top of WIDTH iterations
    localparam int MMM_EXTRA = 3;

    function automatic int monpro_cycles(int w);
        return w + MMM_EXTRA;
    endfunction

endpackage

// File: rtl/mmm_unit.sv
// Bit-serial Montgomery multiplier: Z = A*B*2^-WIDTH mod P, LSB of A first.
// A start pulse always reloads, even mid-operation, so an abandoned run never leaks a done.
module mmm_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] P,
    output logic             done,
    output logic [WIDTH-1:0] Z
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh, b_r, t_sub;
    logic [WIDTH+1:0] t, t_add, t_odd;
    logic [CW-1:0]    cnt;
    logic             busy;

    // T stays below 2P, so T + B + P fits in WIDTH+2 bits
    always_comb begin
        t_add = t + (a_sh[0] ? {2'b00, b_r} : '0);
        t_odd = t_add[0] ? t_add + {2'b00, P} : t_add;
        t_sub = WIDTH'((t >= {2'b00, P}) ? t - {2'b00, P} : t);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_sh <= '0;
            b_r  <= '0;
            t    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            Z    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_sh <= A;
                b_r  <= B;
                t    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt == CW'(WIDTH)) begin
                    Z    <= t_sub;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    t    <= t_odd >> 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_unit.sv
// Modular exponentiation C = M^E mod P by left-to-right square-and-multiply,
// one Montgomery product per sequencer state.
module rsa_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic             eoc,
    output logic [WIDTH-1:0] C
);
    localparam int IW = $clog2(WIDTH);

    state_e           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] p_r, e_r, m_r, k_r, mb, x;
    logic [WIDTH-1:0] op_a, op_b, z;
    logic             start_r, mm_done, step_done;
    opsel_e           sel_a, sel_b;

    function automatic logic [WIDTH-1:0] pick(opsel_e s, logic [WIDTH-1:0] m_v,
                                              logic [WIDTH-1:0] k_v, logic [WIDTH-1:0] mb_v,
                                              logic [WIDTH-1:0] x_v);
        case (s)
            SEL_ONE:   return WIDTH'(1);
            SEL_CONST: return k_v;
            SEL_M:     return m_v;
            SEL_MB:    return mb_v;
            default:   return x_v;
        endcase
    endfunction

    always_comb begin
        sel_a = SEL_X;
        sel_b = SEL_X;
        case (state)
            MBAR:    begin sel_a = SEL_M;   sel_b = SEL_CONST; end
            XINIT:   begin sel_a = SEL_ONE; sel_b = SEL_CONST; end
            MUL:     begin sel_a = SEL_MB;  sel_b = SEL_X;     end
            CONV:    begin sel_a = SEL_X;   sel_b = SEL_ONE;   end
            default: ;
        endcase
        op_a = pick(sel_a, m_r, k_r, mb, x);
        op_b = pick(sel_b, m_r, k_r, mb, x);
    end

    // A done that lands while a fresh dispatch is pending belongs to an aborted run
    assign step_done = mm_done && !start_r;

    mmm_unit #(.WIDTH(WIDTH)) u_mmm (
        .clk   (clk),
        .rstb  (rstb),
        .start (start_r),
        .A     (op_a),
        .B     (op_b),
        .P     (p_r),
        .done  (mm_done),
        .Z     (z)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            idx     <= '0;
            p_r     <= '0;
            e_r     <= '0;
            m_r     <= '0;
            k_r     <= '0;
            mb      <= '0;
            x       <= '0;
            C       <= '0;
            eoc     <= 1'b0;
            start_r <= 1'b0;
        end else begin
            start_r <= 1'b0;
            eoc     <= 1'b0;
            case (state)
                IDLE: if (en) begin
                    p_r     <= P;
                    e_r     <= E;
                    m_r     <= M;
                    k_r     <= Const;
                    state   <= MBAR;
                    start_r <= 1'b1;
                end
                DONE: begin
                    C     <= x;
                    eoc   <= 1'b1;
                    state <= HOLD;
                end
                HOLD: if (!en) state <= IDLE;
                default: if (!en) begin
                    state <= IDLE;
                end else if (step_done) begin
                    start_r <= 1'b1;
                    case (state)
                        MBAR: begin
                            mb    <= z;
                            state <= XINIT;
                        end
                        XINIT: begin
                            x     <= z;
                            idx   <= IW'(WIDTH - 1);
                            state <= SQ;
                        end
                        SQ, MUL: begin
                            x <= z;
                            if (state == SQ && e_r[idx]) begin
                                state <= MUL;
                            end else if (idx == '0) begin
                                state <= CONV;
                            end else begin
                                idx   <= idx - 1'b1;
                                state <= SQ;
                            end
                        end
                        CONV: begin
                            x       <= z;
                            start_r <= 1'b0;
                            state   <= DONE;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_unit.sv
// Directed and reference-model checks for rsa_unit at WIDTH = 8.
module tb_rsa_unit;
    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       en = 1'b0;
    logic [7:0] P = '0, E = '0, M = '0, Const = '0;
    logic       eoc;
    logic [7:0] C;

    int checks = 0;
    int errors = 0;

    rsa_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .en    (en),
        .P     (P),
        .E     (E),
        .M     (M),
        .Const (Const),
        .eoc   (eoc),
        .C     (C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Called #1 after the capture edge; counts edges until eoc shows up
    task automatic measure(input string tag, input int exp_c, input int exp_lat);
        int cyc = 0;
        while (!eoc && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_C"}, C, exp_c);
        @(posedge clk); #1;
        chk({tag, "_eoc_pulse"}, eoc, 0);
    endtask

    task automatic run_op(input string tag, input int p, input int k, input int m,
                          input int e, input int exp_c);
        @(negedge clk);
        P = 8'(p); Const = 8'(k); M = 8'(m); E = 8'(e);
        en = 1'b1;
        @(posedge clk); #1;
        measure(tag, exp_c, (11 + $countones(8'(e))) * 11 + 1);
    endtask

    task automatic stop_op();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic int modexp(int b, int e, int p);
        longint r = 1;
        longint bb = b % p;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * bb) % p;
            bb = (bb * bb) % p;
        end
        return int'(r % p);
    endfunction

    initial begin
        int eoc_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_C", C, 0);
        chk("reset_eoc", eoc, 0);
        @(negedge clk);
        rstb = 1'b1;

        run_op("encrypt", 187, 86, 88, 7, 11);
        stop_op();

        run_op("decrypt", 187, 86, 11, 23, 88);
        eoc_cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (eoc) eoc_cnt++;
        end
        chk("hold_no_eoc", eoc_cnt, 0);
        chk("hold_C", C, 88);
        stop_op();

        run_op("e_zero", 187, 86, 88, 0, 1);
        stop_op();
        run_op("m_zero", 187, 86, 0, 7, 0);
        stop_op();
        run_op("e_one", 187, 86, 88, 1, 88);

        // Abort: encrypt operands, en dropped 60 cycles in; C must stay 88
        stop_op();
        @(negedge clk);
        P = 8'd187; Const = 8'd86; M = 8'd88; E = 8'd7;
        en = 1'b1;
        eoc_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (eoc) eoc_cnt++;
        end
        @(negedge clk);
        en = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (eoc) eoc_cnt++;
        end
        chk("abort_no_eoc", eoc_cnt, 0);
        chk("abort_C", C, 88);
        run_op("restart", 187, 86, 11, 23, 88);
        stop_op();

        // Asynchronous reset 80 cycles into an encrypt run
        @(negedge clk);
        P = 8'd187; Const = 8'd86; M = 8'd88; E = 8'd7;
        en = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_C", C, 0);
        chk("async_rst_eoc", eoc, 0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;
        measure("post_reset", 11, 155);
        stop_op();

        for (int n = 0; n < 200; n++) begin
            int p, m, e;
            p = $urandom_range(1, 127) * 2 + 1;
            m = $urandom_range(0, p - 1);
            e = $urandom_range(0, 255);
            run_op($sformatf("rand%0d_p%0d_m%0d_e%0d", n, p, m, e), p, 65536 % p, m, e,
                   modexp(m, e, p));
            stop_op();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
